// File: rtl/johnson_seq_ctrl.sv
// johnson_seq_ctrl: command-driven sequencer around a WIDTH-bit Johnson ring.
// Accepts step/continuous commands over valid/ready and shifts the ring
// forward or backward, with pause, stop, done and wrap status.
// Optional feature macro: JOHNSON_SEQ_SELFCHK_EN enables the illegal-code
// checker (err pulse, ring cleared, active command aborted via DONE).
module johnson_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic             cmd_cont,
    input  logic             pause,
    input  logic             stop,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [CNT_W-1:0] remaining,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] remaining_q;
    logic             dir_q;
    logic             cont_q;
    logic             wrap_q;
    logic             err_q;

    logic             accept;
    logic [WIDTH-1:0] shift_d;
    logic             illegal;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign out       = out_q;
    assign wrap      = wrap_q;
    assign remaining = remaining_q;
    assign err       = err_q;

    // Next ring value for one step in the latched direction.
    always_comb begin
        shift_d = '0;
        if (dir_q) begin
            shift_d = {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
        end else begin
            shift_d = {~out_q[0], out_q[WIDTH-1:1]};
        end
    end

`ifdef JOHNSON_SEQ_SELFCHK_EN
    // A legal Johnson code has at most one boundary between adjacent bits.
    always_comb begin
        int unsigned trans;
        trans = 0;
        for (int unsigned i = 0; i < WIDTH - 1; i++) begin
            if (out_q[i] != out_q[i+1]) begin
                trans++;
            end
        end
        illegal = (trans > 1);
    end
`else
    assign illegal = 1'b0;
`endif

    // Sequencer FSM with registered ring, counter and status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            cont_q      <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            err_q  <= illegal;
            if (illegal) begin
                // Checker recovery overrides all normal activity; a live or
                // just-accepted command is closed out through DONE.
                out_q       <= '0;
                remaining_q <= '0;
                state_q     <= (state_q == RUN || accept) ? DONE : IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            dir_q       <= cmd_dir;
                            cont_q      <= cmd_cont;
                            remaining_q <= cmd_cont ? '0 : cmd_steps;
                            state_q     <= (!cmd_cont && cmd_steps == '0) ? DONE : RUN;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            remaining_q <= '0;
                            state_q     <= DONE;
                        end else if (!pause) begin
                            out_q  <= shift_d;
                            wrap_q <= (shift_d == '0);
                            if (!cont_q) begin
                                remaining_q <= remaining_q - 1'b1;
                                if (remaining_q == CNT_W'(1)) begin
                                    state_q <= DONE;
                                end
                            end
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
